addr_rule_decode: RTL and testbench

- Rule-based address decoder that maps an input address onto an index through a table of half-open address ranges.
- Used by register and APB slaves (e.g. read-only register banks) to select a register and detect out-of-range accesses.
- Decode path is purely combinational with zero latency.
- A small clocked monitor accumulates decode-error statistics for debug.

---
 rtl/addr_rule_decode.sv | 81 ++++++++
 tb/tb_addr_rule_decode.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_rule_decode.sv
// Address decoder: maps an address onto an index through a table of half-open ranges,
// plus a small clocked monitor that accumulates sampled decode errors for debug.
module addr_rule_decode #(
    parameter int unsigned NoIndices = 1,
    parameter int unsigned NoRules   = 1,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned CntWidth  = 16,
    localparam int unsigned IdxWidth = (NoIndices > 1) ? $clog2(NoIndices) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [AddrWidth-1:0]                  addr_i,
    input  logic [NoRules*(32+2*AddrWidth)-1:0]   addr_map_i,
    input  logic                                  en_default_idx_i,
    input  logic [IdxWidth-1:0]                   default_idx_i,
    input  logic                                  sample_i,
    input  logic                                  clear_i,
    output logic [IdxWidth-1:0]                   idx_o,
    output logic                                  dec_valid_o,
    output logic                                  dec_error_o,
    output logic                                  err_sticky_o,
    output logic [CntWidth-1:0]                   err_cnt_o
);
    localparam int unsigned RuleWidth = 32 + 2 * AddrWidth;

    logic [31:0]          rule_idx   [NoRules];
    logic [AddrWidth-1:0] rule_start [NoRules];
    logic [AddrWidth-1:0] rule_end   [NoRules];
    logic [NoRules-1:0]   rule_hit;

    // An end address of zero means the range runs to the top of the address space.
    for (genvar r = 0; r < NoRules; r++) begin : g_rule
        assign {rule_idx[r], rule_start[r], rule_end[r]} = addr_map_i[r*RuleWidth +: RuleWidth];
        assign rule_hit[r] = (addr_i >= rule_start[r]) &&
                             ((rule_end[r] == '0) || (addr_i < rule_end[r]));
    end

    // Ascending scan so the highest-numbered matching rule is the one left standing.
    always_comb begin
        idx_o       = en_default_idx_i ? default_idx_i : '0;
        dec_valid_o = 1'b0;
        for (int r = 0; r < int'(NoRules); r++) begin
            if (rule_hit[r]) begin
                idx_o       = rule_idx[r][IdxWidth-1:0];
                dec_valid_o = 1'b1;
            end
        end
        dec_error_o = !dec_valid_o && !en_default_idx_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_sticky_o <= 1'b0;
            err_cnt_o    <= '0;
        end else if (clear_i) begin
            err_sticky_o <= 1'b0;
            err_cnt_o    <= '0;
        end else if (sample_i && dec_error_o) begin
            err_sticky_o <= 1'b1;
            if (err_cnt_o != '1) begin
                err_cnt_o <= err_cnt_o + CntWidth'(1);
            end
        end
    end

`ifndef SYNTHESIS
    if (NoRules == 0 || NoIndices == 0 || AddrWidth == 0) begin : g_param_check
        $fatal(1, "addr_rule_decode: NoRules, NoIndices and AddrWidth must be non-zero");
    end

    always @(posedge clk_i) begin
        for (int r = 0; r < int'(NoRules); r++) begin
            if (rule_idx[r] >= NoIndices)
                $error("addr_rule_decode: rule %0d idx %0d out of range", r, rule_idx[r]);
            if ((rule_end[r] != '0) && (rule_end[r] <= rule_start[r]))
                $error("addr_rule_decode: rule %0d has an inverted range", r);
        end
    end
`endif

endmodule

// File: tb/tb_addr_rule_decode.sv
// Randomized bench for addr_rule_decode: a range-table reference model predicts the decode
// and the error monitor for a 16-bit-counter and a 2-bit-counter instance.
module tb_addr_rule_decode;
    localparam int NR = 4;
    localparam int NI = 4;
    localparam int RW = 96;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     addr = '0;
    logic [NR*RW-1:0] addr_map = '0;
    logic            en_def = 1'b0;
    logic [1:0]      def_idx = '0;
    logic            sample = 1'b0;
    logic            clear = 1'b0;

    logic [1:0]  idx_a, idx_b;
    logic        vld_a, vld_b, err_a, err_b, sticky_a, sticky_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_idx   [NR];
    logic [31:0] m_start [NR];
    logic [31:0] m_end   [NR];
    int          m_cnt16 = 0;
    int          m_cnt2  = 0;
    bit          m_sticky = 1'b0;

    always #5 clk = ~clk;

    addr_rule_decode #(.NoIndices(NI), .NoRules(NR), .AddrWidth(32), .CntWidth(16)) dut_a (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .addr_map_i(addr_map),
        .en_default_idx_i(en_def), .default_idx_i(def_idx), .sample_i(sample), .clear_i(clear),
        .idx_o(idx_a), .dec_valid_o(vld_a), .dec_error_o(err_a),
        .err_sticky_o(sticky_a), .err_cnt_o(cnt_a));

    addr_rule_decode #(.NoIndices(NI), .NoRules(NR), .AddrWidth(32), .CntWidth(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .addr_map_i(addr_map),
        .en_default_idx_i(en_def), .default_idx_i(def_idx), .sample_i(sample), .clear_i(clear),
        .idx_o(idx_b), .dec_valid_o(vld_b), .dec_error_o(err_b),
        .err_sticky_o(sticky_b), .err_cnt_o(cnt_b));

    // Reference: scan the range table from the highest rule down, first hit wins.
    function automatic void model_dec(input logic [31:0] a, output logic [1:0] e_idx,
                                      output bit e_vld, output bit e_err);
        e_vld = 1'b0;
        e_idx = en_def ? def_idx : 2'd0;
        for (int r = NR - 1; r >= 0; r--) begin
            if (a >= m_start[r] && (m_end[r] == 0 || a < m_end[r])) begin
                e_idx = 2'(m_idx[r] % NI);
                e_vld = 1'b1;
                break;
            end
        end
        e_err = !e_vld && !en_def;
    endfunction

    task automatic load_map();
        logic [NR*RW-1:0] m;
        m = '0;
        for (int r = 0; r < NR; r++) m[r*RW +: RW] = {m_idx[r], m_start[r], m_end[r]};
        addr_map = m;
    endtask

    task automatic set_rule(input int r, input logic [31:0] i, input logic [31:0] s,
                            input logic [31:0] e);
        m_idx[r] = i; m_start[r] = s; m_end[r] = e;
    endtask

    task automatic plan_map();
        for (int r = 0; r < NR; r++)
            set_rule(r, r, 32'h1000 + 4 * r, 32'h1004 + 4 * r);
        load_map();
    endtask

    // One clock edge; the monitor model advances from the inputs seen at the edge.
    task automatic tick();
        logic [1:0] ei;
        bit ev, ee;
        model_dec(addr, ei, ev, ee);
        @(posedge clk);
        #1;
        if (clear) begin
            m_cnt16 = 0; m_cnt2 = 0; m_sticky = 1'b0;
        end else if (sample && ee) begin
            m_sticky = 1'b1;
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic test_reset();
        plan_map();
        addr = 32'h1004;
        #1;
        total++;
        if (sticky_a !== 1'b0 || cnt_a !== 16'd0 || sticky_b !== 1'b0 || cnt_b !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: sticky=%b cnt=%0d cnt2=%0d required 0/0/0", sticky_a, cnt_a, cnt_b);
        end
        total++;
        if (idx_a !== 2'd1 || vld_a !== 1'b1 || err_a !== 1'b0) begin
            bad++;
            $display("FAIL decode_in_reset: idx=%0d vld=%b err=%b required 1/1/0", idx_a, vld_a, err_a);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_map();
        logic [31:0] addrs [3] = '{32'h1000, 32'h100B, 32'h100F};
        logic [1:0]  exp_i [3] = '{2'd0, 2'd2, 2'd3};
        plan_map();
        en_def = 1'b0;
        for (int k = 0; k < 3; k++) begin
            addr = addrs[k];
            #1;
            total++;
            if (idx_a !== exp_i[k] || vld_a !== 1'b1 || err_a !== 1'b0) begin
                bad++;
                $display("FAIL map_hit %h: idx=%0d vld=%b err=%b required %0d/1/0",
                         addrs[k], idx_a, vld_a, err_a, exp_i[k]);
            end
        end
    endtask

    task automatic test_miss();
        plan_map();
        addr = 32'h1010; en_def = 1'b0; def_idx = 2'd1;
        #1;
        total++;
        if (idx_a !== 2'd0 || vld_a !== 1'b0 || err_a !== 1'b1) begin
            bad++;
            $display("FAIL miss_nodef: idx=%0d vld=%b err=%b required 0/0/1", idx_a, vld_a, err_a);
        end
        en_def = 1'b1;
        #1;
        total++;
        if (idx_a !== 2'd1 || vld_a !== 1'b0 || err_a !== 1'b0) begin
            bad++;
            $display("FAIL miss_def: idx=%0d vld=%b err=%b required 1/0/0", idx_a, vld_a, err_a);
        end
        en_def = 1'b0;
    endtask

    task automatic test_overlap();
        set_rule(0, 0, 32'h0, 32'h100);
        set_rule(1, 1, 32'h80, 32'h90);
        set_rule(2, 0, 32'h7000_0000, 32'h7000_0001);
        set_rule(3, 0, 32'h7000_0010, 32'h7000_0011);
        load_map();
        addr = 32'h84;
        #1;
        total++;
        if (idx_a !== 2'd1 || vld_a !== 1'b1) begin
            bad++;
            $display("FAIL overlap_prio: idx=%0d vld=%b required 1/1", idx_a, vld_a);
        end
        addr = 32'h90;
        #1;
        total++;
        if (idx_a !== 2'd0 || vld_a !== 1'b1) begin
            bad++;
            $display("FAIL overlap_excl_end: idx=%0d vld=%b required 0/1", idx_a, vld_a);
        end
    endtask

    task automatic test_wrap();
        set_rule(0, 0, 32'h7000_0000, 32'h7000_0001);
        set_rule(1, 1, 32'h7000_0010, 32'h7000_0011);
        set_rule(2, 3, 32'h7000_0020, 32'h7000_0021);
        set_rule(3, 2, 32'hFFFF_FFFC, 32'h0);
        load_map();
        addr = 32'hFFFF_FFFF;
        #1;
        total++;
        if (idx_a !== 2'd2 || vld_a !== 1'b1) begin
            bad++;
            $display("FAIL wrap_hit: idx=%0d vld=%b required 2/1", idx_a, vld_a);
        end
        addr = 32'hFFFF_FFF8;
        #1;
        total++;
        if (vld_a !== 1'b0 || err_a !== 1'b1 || idx_a !== 2'd0) begin
            bad++;
            $display("FAIL wrap_miss: idx=%0d vld=%b err=%b required 0/0/1", idx_a, vld_a, err_a);
        end
    endtask

    task automatic test_count();
        plan_map();
        addr = 32'h1010; en_def = 1'b0; sample = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0; sample = 1'b1;
        repeat (3) tick();
        total++;
        if (cnt_a !== 16'd3 || sticky_a !== 1'b1) begin
            bad++;
            $display("FAIL count3: cnt=%0d sticky=%b required 3/1", cnt_a, sticky_a);
        end
        sample = 1'b0;
        tick();
        total++;
        if (cnt_a !== 16'd3 || cnt_b !== 2'd3 || sticky_a !== 1'b1) begin
            bad++;
            $display("FAIL no_sample_hold: cnt=%0d cnt2=%0d sticky=%b required 3/3/1", cnt_a, cnt_b, sticky_a);
        end
        sample = 1'b1;
        repeat (2) tick();
        total++;
        if (cnt_b !== 2'd3 || cnt_a !== 16'd5 || sticky_b !== 1'b1) begin
            bad++;
            $display("FAIL saturate: cnt2=%0d cnt=%0d sticky2=%b required 3/5/1", cnt_b, cnt_a, sticky_b);
        end
        sample = 1'b0;
    endtask

    task automatic test_clear();
        plan_map();
        addr = 32'h1010; en_def = 1'b0; sample = 1'b1; clear = 1'b1;
        tick();
        total++;
        if (cnt_a !== 16'd0 || sticky_a !== 1'b0 || cnt_b !== 2'd0 || sticky_b !== 1'b0) begin
            bad++;
            $display("FAIL clear_prio: cnt=%0d sticky=%b cnt2=%0d required 0/0/0", cnt_a, sticky_a, cnt_b);
        end
        clear = 1'b0;
        tick();
        total++;
        if (cnt_a !== 16'd1 || sticky_a !== 1'b1) begin
            bad++;
            $display("FAIL count_after_clear: cnt=%0d sticky=%b required 1/1", cnt_a, sticky_a);
        end
        sample = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] ei;
        bit ev, ee;
        for (int it = 0; it < 300; it++) begin
            if (it % 25 == 0) begin
                for (int r = 0; r < NR; r++) begin
                    m_start[r] = $urandom_range(0, 'h3000);
                    m_end[r]   = ($urandom_range(0, 7) == 0) ? 32'h0
                                 : m_start[r] + $urandom_range(1, 'h800);
                    m_idx[r]   = $urandom_range(0, NI - 1);
                end
                load_map();
            end
            addr    = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 'h4000);
            en_def  = $urandom_range(0, 3) == 0;
            def_idx = 2'($urandom_range(0, 3));
            sample  = $urandom_range(0, 1) == 1;
            clear   = $urandom_range(0, 19) == 0;
            #1;
            model_dec(addr, ei, ev, ee);
            total++;
            if (idx_a !== ei || vld_a !== ev || err_a !== ee || idx_b !== ei) begin
                bad++;
                $display("FAIL rand_decode %h: idx=%0d vld=%b err=%b required %0d/%b/%b",
                         addr, idx_a, vld_a, err_a, ei, ev, ee);
            end
            tick();
            total++;
            if (cnt_a !== 16'(m_cnt16) || cnt_b !== 2'(m_cnt2) || sticky_a !== m_sticky) begin
                bad++;
                $display("FAIL rand_monitor: cnt=%0d cnt2=%0d sticky=%b required %0d/%0d/%b",
                         cnt_a, cnt_b, sticky_a, m_cnt16, m_cnt2, m_sticky);
            end
        end
        sample = 1'b0; clear = 1'b0;
    endtask

    task automatic test_async_reset();
        plan_map();
        addr = 32'h1010; en_def = 1'b0; sample = 1'b1; clear = 1'b0;
        repeat (2) tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (cnt_a !== 16'd0 || sticky_a !== 1'b0 || cnt_b !== 2'd0 || sticky_b !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: cnt=%0d sticky=%b cnt2=%0d required 0/0/0", cnt_a, sticky_a, cnt_b);
        end
        addr = 32'h1008;
        #1;
        total++;
        if (idx_a !== 2'd2 || vld_a !== 1'b1 || err_a !== 1'b0) begin
            bad++;
            $display("FAIL decode_during_reset: idx=%0d vld=%b err=%b required 2/1/0", idx_a, vld_a, err_a);
        end
        #1;
        rst = 1'b0; sample = 1'b0;
        m_cnt16 = 0; m_cnt2 = 0; m_sticky = 1'b0;
    endtask

    initial begin
        test_reset();
        test_map();
        test_miss();
        test_overlap();
        test_wrap();
        test_count();
        test_clear();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
